// File: rtl/output_sram_writer_pkg.sv
// Shared definitions for the output SRAM writer: FSM state encoding,
// default bus widths and the matrix-size header word format.
package output_sram_writer_pkg;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 16;

   // Upper byte of the size header word; the lower byte carries D.
   localparam logic [7:0] HDR_HI_BYTE = 8'h00;
   // Pad byte used when an odd pixel count leaves a half-filled word.
   localparam logic [7:0] FLUSH_LO_BYTE = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_COLLECT_HI,
      ST_COLLECT_LO,
      ST_FLUSH,
      ST_DONE
   } state_t;

   function automatic logic [15:0] header_word(input logic [7:0] dim);
      return {HDR_HI_BYTE, dim};
   endfunction

endpackage

// File: rtl/output_sram_writer_byte_pair_packer.sv
// Byte-pair packer: holds the high byte of a word until its low byte
// arrives, and produces the zero-padded word when the matrix ends on an
// odd pixel.
module output_sram_writer_byte_pair_packer
   import output_sram_writer_pkg::*;
(
   input  logic        clk,
   input  logic        srst,
   input  logic        clear,
   input  logic        hi_load,
   input  logic [7:0]  pix_byte,
   input  logic        flush,
   output logic [15:0] word
);

   logic [7:0] hi_byte_reg;

   // Capture the high byte; a new matrix or reset drops any partial word.
   always_ff @(posedge clk) begin
      if (srst || clear) begin
         hi_byte_reg <= 8'h00;
      end else if (hi_load) begin
         hi_byte_reg <= pix_byte;
      end
   end

   // Word seen by the writer: paired with the live pixel, or padded on flush.
   always_comb begin
      word = {hi_byte_reg, pix_byte};
      if (flush) begin
         word = {hi_byte_reg, FLUSH_LO_BYTE};
      end
   end

endmodule

// File: rtl/output_sram_writer.sv
// Output SRAM writer: packs a D x D matrix of 8-bit ReLU pixels into
// 16-bit words and writes them to consecutive SRAM addresses.
// Optional feature: define OSRAM_SIZE_HEADER_EN to prefix every matrix
// with a {8'h00, D} size word.
// Note: reset_b is an active-high synchronous reset despite its name.
module output_sram_writer
   import output_sram_writer_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                DATA_W    = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              mat_start,
   input  logic [7:0]        mat_dim,
   input  logic              pix_valid,
   input  logic [7:0]        pix_data,
   output logic              pix_ready,
   output logic              output_sram_write_enable,
   output logic [ADDR_W-1:0] output_sram_write_addresss,
   output logic [DATA_W-1:0] output_sram_write_data,
   output logic              writer_busy,
   output logic              mat_done
);

   state_t            state_reg, state_next;
   logic [7:0]        dim_reg;
   logic [12:0]       pix_cnt_reg;
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   logic              done_reg;

   logic [15:0] dim_sq;
   logic [12:0] cnt_inc;
   logic        last_pix;
   logic        accept;
   logic        start_accept;
   logic        pix_ready_c;
   logic        busy_c;
   logic        issue_write;
   logic        hi_load;
   logic        flush_sel;
   logic        header_sel;
   logic [15:0] packer_word;
   logic [15:0] wr_word;

   assign dim_sq       = {8'h00, dim_reg} * {8'h00, dim_reg};
   assign cnt_inc      = pix_cnt_reg + 13'd1;
   assign last_pix     = ({3'b000, cnt_inc} == dim_sq);
   assign accept       = pix_valid & pix_ready_c;
   // mat_start is only honoured from IDLE, so a pulse mid-matrix is dropped.
   assign start_accept = (state_reg == ST_IDLE) & mat_start;

   // State register.
   always_ff @(posedge clk) begin
      if (reset_b) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; DONE always lasts one cycle before returning to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (mat_start) begin
`ifdef OSRAM_SIZE_HEADER_EN
               state_next = ST_HEADER;
`else
               state_next = (mat_dim == 8'd0) ? ST_DONE : ST_COLLECT_HI;
`endif
            end
         end
         ST_HEADER: begin
            state_next = (dim_reg == 8'd0) ? ST_DONE : ST_COLLECT_HI;
         end
         ST_COLLECT_HI: begin
            if (accept) begin
               state_next = last_pix ? ST_FLUSH : ST_COLLECT_LO;
            end
         end
         ST_COLLECT_LO: begin
            if (accept) begin
               state_next = last_pix ? ST_DONE : ST_COLLECT_HI;
            end
         end
         ST_FLUSH: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Per-state handshake and write-issue decode.
   always_comb begin
      pix_ready_c = 1'b0;
      busy_c      = 1'b1;
      issue_write = 1'b0;
      hi_load     = 1'b0;
      flush_sel   = 1'b0;
      header_sel  = 1'b0;
      case (state_reg)
         ST_IDLE: busy_c = 1'b0;
         ST_HEADER: begin
            issue_write = 1'b1;
            header_sel  = 1'b1;
         end
         ST_COLLECT_HI: begin
            pix_ready_c = 1'b1;
            hi_load     = accept;
         end
         ST_COLLECT_LO: begin
            pix_ready_c = 1'b1;
            issue_write = accept;
         end
         ST_FLUSH: begin
            issue_write = 1'b1;
            flush_sel   = 1'b1;
         end
         default: ;
      endcase
   end

   output_sram_writer_byte_pair_packer byte_pair_packer (
      .clk      (clk),
      .srst     (reset_b),
      .clear    (start_accept),
      .hi_load  (hi_load),
      .pix_byte (pix_data),
      .flush    (flush_sel),
      .word     (packer_word)
   );

   assign wr_word = header_sel ? header_word(dim_reg) : packer_word;

   // Matrix bookkeeping and registered SRAM port; the address pointer
   // survives across matrices and only reset returns it to BASE_ADDR.
   always_ff @(posedge clk) begin
      if (reset_b) begin
         dim_reg     <= 8'h00;
         pix_cnt_reg <= 13'd0;
         wr_ptr_reg  <= BASE_ADDR;
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         data_reg    <= '0;
         done_reg    <= 1'b0;
      end else begin
         we_reg   <= issue_write;
         done_reg <= (state_reg == ST_DONE);
         if (start_accept) begin
            dim_reg     <= mat_dim;
            pix_cnt_reg <= 13'd0;
         end else if (accept) begin
            pix_cnt_reg <= cnt_inc;
         end
         if (issue_write) begin
            addr_reg   <= wr_ptr_reg;
            data_reg   <= DATA_W'(wr_word);
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
         end
      end
   end

   assign pix_ready                  = pix_ready_c;
   assign writer_busy                = busy_c;
   assign output_sram_write_enable   = we_reg;
   assign output_sram_write_addresss = addr_reg;
   assign output_sram_write_data     = data_reg;
   assign mat_done                   = done_reg;

endmodule

// File: tb/tb_output_sram_writer.sv
// Scoreboard bench for output_sram_writer: stimulus pushes expected
// {address, data} words, a negedge monitor pops them on every write.
module tb_output_sram_writer;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        mat_start;
   logic [7:0]  mat_dim;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_ready;
   logic        output_sram_write_enable;
   logic [11:0] output_sram_write_addresss;
   logic [15:0] output_sram_write_data;
   logic        writer_busy;
   logic        mat_done;

   always #5 clk = ~clk;

   output_sram_writer #(
      .ADDR_W    (12),
      .DATA_W    (16),
      .BASE_ADDR (12'h000)
   ) dut (
      .clk                        (clk),
      .reset_b                    (reset_b),
      .mat_start                  (mat_start),
      .mat_dim                    (mat_dim),
      .pix_valid                  (pix_valid),
      .pix_data                   (pix_data),
      .pix_ready                  (pix_ready),
      .output_sram_write_enable   (output_sram_write_enable),
      .output_sram_write_addresss (output_sram_write_addresss),
      .output_sram_write_data     (output_sram_write_data),
      .writer_busy                (writer_busy),
      .mat_done                   (mat_done)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [27:0] exp_q[$];
   bit          done_q[$];
   logic [11:0] exp_addr;
   logic [7:0]  pix_mem [0:8191];
   int          cyc         = 0;
   int          last_we_cyc = -10;
   bit          prev_fff    = 1'b0;
   bit          saw_wrap    = 1'b0;
   bit          quiet       = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Monitor: pop one expected word per write, one expected done per mat_done.
   always @(negedge clk) begin : monitor
      logic [27:0] e;
      bit          f;
      cyc++;
      if (output_sram_write_enable) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_write", $sformatf("got addr 0x%03h data 0x%04h, expected no write",
                     output_sram_write_addresss, output_sram_write_data));
         end else begin
            e = exp_q.pop_front();
            check("write_addr", {20'd0, output_sram_write_addresss}, {20'd0, e[27:16]});
            check("write_data", {16'd0, output_sram_write_data}, {16'd0, e[15:0]});
            if (!quiet)
               $display("write addr=0x%03h data=0x%04h (exp 0x%03h/0x%04h)",
                        output_sram_write_addresss, output_sram_write_data, e[27:16], e[15:0]);
         end
         if (prev_fff && output_sram_write_addresss == 12'h000) saw_wrap = 1'b1;
         prev_fff    = (output_sram_write_addresss == 12'hFFF);
         last_we_cyc = cyc;
      end
      if (mat_done) begin
         if (done_q.size() == 0) begin
            fail_now("unexpected_mat_done", "got mat_done=1, expected 0");
         end else begin
            f = done_q.pop_front();
            if (f) check("done_after_write", cyc - last_we_cyc, 1);
            check("busy_at_done", {31'd0, writer_busy}, 0);
            $display("mat_done at cycle %0d", cyc);
         end
      end
   end

   task automatic push_word(input logic [15:0] d);
      exp_q.push_back({exp_addr, d});
      exp_addr = exp_addr + 12'd1;
   endtask

   task automatic start_matrix(input logic [7:0] d, input bit expect_done, input bit done_after_write);
`ifdef OSRAM_SIZE_HEADER_EN
      push_word({8'h00, d});
`endif
      if (expect_done) done_q.push_back(done_after_write);
      @(negedge clk);
      mat_start = 1'b1;
      mat_dim   = d;
      @(negedge clk);
      mat_start = 1'b0;
      check("busy_after_start", {31'd0, writer_busy}, 1);
   endtask

   task automatic feed(input int n, input bit gap, input int mid_at);
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin
               @(negedge clk);
               pix_valid = 1'b0;
               mat_start = 1'b0;
            end
         end
         @(negedge clk);
         pix_valid = 1'b1;
         pix_data  = pix_mem[i];
         mat_start = (i == mid_at);
         if (i == mid_at) mat_dim = 8'd5;
         begin
            int t = 0;
            while (!pix_ready && t < 64) begin
               @(negedge clk);
               mat_start = 1'b0;
               t++;
            end
            if (!pix_ready) fail_now("pix_ready_timeout", $sformatf("pixel %0d never accepted", i));
         end
      end
      @(negedge clk);
      pix_valid = 1'b0;
      mat_start = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (!mat_done && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (!mat_done) fail_now("mat_done_timeout", "got no mat_done within 64 cycles");
      @(negedge clk);
   endtask

   initial begin
      reset_b   = 1'b1;
      mat_start = 1'b0;
      mat_dim   = 8'd0;
      pix_valid = 1'b0;
      pix_data  = 8'd0;
      exp_addr  = 12'h000;
      repeat (3) @(negedge clk);
      // Outputs while reset is held.
      check("rst_we",    {31'd0, output_sram_write_enable}, 0);
      check("rst_addr",  {20'd0, output_sram_write_addresss}, 0);
      check("rst_data",  {16'd0, output_sram_write_data}, 0);
      check("rst_ready", {31'd0, pix_ready}, 0);
      check("rst_busy",  {31'd0, writer_busy}, 0);
      check("rst_done",  {31'd0, mat_done}, 0);
      reset_b = 1'b0;
      @(negedge clk);

      // D=2, even pixel count.
      pix_mem[0] = 8'h11; pix_mem[1] = 8'h22; pix_mem[2] = 8'h33; pix_mem[3] = 8'h44;
      start_matrix(8'd2, 1'b1, 1'b1);
      push_word(16'h1122);
      push_word(16'h3344);
      feed(4, 1'b0, -1);
      wait_done();

      // D=3, odd pixel count ends with a padded flush word.
      for (int i = 0; i < 9; i++) pix_mem[i] = 8'(i + 1);
      start_matrix(8'd3, 1'b1, 1'b1);
      push_word(16'h0102); push_word(16'h0304); push_word(16'h0506);
      push_word(16'h0708); push_word(16'h0900);
      feed(9, 1'b0, -1);
      check("ready_low_after_last", {31'd0, pix_ready}, 0);
      wait_done();

      // Back-to-back matrices D=2 then D=1.
      pix_mem[0] = 8'hAA; pix_mem[1] = 8'hBB; pix_mem[2] = 8'hCC; pix_mem[3] = 8'hDD;
      start_matrix(8'd2, 1'b1, 1'b1);
      push_word(16'hAABB);
      push_word(16'hCCDD);
      feed(4, 1'b0, -1);
      wait_done();
      pix_mem[0] = 8'h7F;
      start_matrix(8'd1, 1'b1, 1'b1);
      push_word(16'h7F00);
      feed(1, 1'b0, -1);
      wait_done();

      // D=0: no pixels, only the optional header precedes mat_done.
`ifdef OSRAM_SIZE_HEADER_EN
      start_matrix(8'd0, 1'b1, 1'b1);
`else
      start_matrix(8'd0, 1'b1, 1'b0);
`endif
      check("d0_ready", {31'd0, pix_ready}, 0);
      wait_done();

      // Gapped valid plus a stray mat_start mid-matrix: same words as gap-free.
      for (int i = 0; i < 9; i++) pix_mem[i] = 8'(i + 1);
      start_matrix(8'd3, 1'b1, 1'b1);
      push_word(16'h0102); push_word(16'h0304); push_word(16'h0506);
      push_word(16'h0708); push_word(16'h0900);
      feed(9, 1'b1, 4);
      wait_done();
      check("busy_idle_after_gapped", {31'd0, writer_busy}, 0);

      // Reset after 3 of 4 pixels: stale partial word must never be written.
      for (int i = 0; i < 4; i++) pix_mem[i] = 8'(i + 1);
      start_matrix(8'd2, 1'b0, 1'b0);
      push_word(16'h0102);
      feed(3, 1'b0, -1);
      repeat (3) @(negedge clk);
      check("pre_reset_drained", exp_q.size(), 0);
      reset_b = 1'b1;
      repeat (2) @(negedge clk);
      reset_b  = 1'b0;
      exp_addr = 12'h000;
      @(negedge clk);
      check("post_reset_busy", {31'd0, writer_busy}, 0);
      check("post_reset_we", {31'd0, output_sram_write_enable}, 0);
      start_matrix(8'd2, 1'b1, 1'b1);
      push_word(16'h0102);
      push_word(16'h0304);
      feed(4, 1'b0, -1);
      wait_done();

      // Large matrix to walk the address pointer near 0xFFF.
      quiet = 1'b1;
      for (int i = 0; i < 8100; i++) pix_mem[i] = 8'(i * 7 + 3);
      start_matrix(8'd90, 1'b1, 1'b1);
      for (int i = 0; i < 4050; i++) push_word({pix_mem[2*i], pix_mem[2*i+1]});
      feed(8100, 1'b0, -1);
      wait_done();
      quiet = 1'b0;
      $display("bulk matrix done, next expected address 0x%03h", exp_addr);

      // This matrix straddles 0xFFF -> 0x000.
      for (int i = 0; i < 100; i++) pix_mem[i] = 8'(i * 13 + 1);
      start_matrix(8'd10, 1'b1, 1'b1);
      for (int i = 0; i < 50; i++) push_word({pix_mem[2*i], pix_mem[2*i+1]});
      feed(100, 1'b0, -1);
      wait_done();
      check("address_wrapped", {31'd0, saw_wrap}, 1);

      repeat (5) @(negedge clk);
      check("exp_queue_empty", exp_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/output_sram_writer.md
OUTPUT_SRAM_WRITER -- requirements
Module: output_sram_writer

Interface
REQ-001 Parameter ADDR_W, 12, SRAM address width.
REQ-002 Parameter DATA_W, 16, SRAM word width.
REQ-003 Parameter BASE_ADDR, 12'h000, first output SRAM address written after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_b  input  1  synchronous, active-high reset.
REQ-006 mat_start  input  1  one-cycle pulse that begins a new output matrix.
REQ-007 mat_dim  input  8  output matrix dimension D (D x D pixels), sampled with mat_start.
REQ-008 pix_valid  input  1  pixel offered.
REQ-009 pix_data  input  8  ReLU pixel, row-major order.
REQ-010 pix_ready  output  1  writer accepts pixel; a pixel transfers when pix_valid & pix_ready.
REQ-011 output_sram_write_enable  output  1  write strobe.
REQ-012 output_sram_write_addresss  output  ADDR_W  write address.
REQ-013 output_sram_write_data  output  DATA_W  write data.
REQ-014 writer_busy  output  1  high from accepted mat_start until the last word of the matrix is written.
REQ-015 mat_done  output  1  one-cycle pulse in the cycle after the final write of a matrix.

Function
REQ-016 FSM states: IDLE, HEADER, COLLECT_HI, COLLECT_LO, FLUSH, DONE.
REQ-017 IDLE: pix_ready=0, writer_busy=0; mat_start -> HEADER (macro on) or COLLECT_HI (macro off); D latched.
REQ-018 mat_start while writer_busy=1 is ignored.
REQ-019 D=0: no pixel accepted; FSM -> DONE after the header (macro on) or directly (macro off).
REQ-020 COLLECT_HI: pix_ready=1; accepted pixel stored as word bits [15:8] -> COLLECT_LO.
REQ-021 COLLECT_LO: pix_ready=1; accepted pixel forms bits [7:0]; write issued the next cycle -> COLLECT_HI.
REQ-022 All SRAM outputs are registered: write_enable high for exactly one cycle per word, the cycle after the completing pixel is accepted.
REQ-023 13-bit pixel counter; when count reaches D*D, pix_ready drops the next cycle and no further pixels are accepted.
REQ-024 D*D odd: last pixel accepted in COLLECT_HI -> FLUSH writes {pixel, 8'h00}.
REQ-025 After the final write -> DONE: mat_done=1 for one cycle -> IDLE.
REQ-026 Write address increments by 1 after every write, wraps 12'hFFF -> 12'h000, and persists across matrices.
REQ-027 With pix_valid=0, the writer holds state indefinitely; no timeout.
REQ-028 write_enable=0 whenever no write is issued; write_data holds its last value.

Reset
REQ-029 Reset: FSM=IDLE, write address=BASE_ADDR, pixel counter=0, partial byte cleared, all outputs 0.
REQ-030 Reset mid-matrix discards the partial word without writing it; mat_done is not pulsed.

Configuration
REQ-031 Macro OSRAM_SIZE_HEADER_EN defined: HEADER state writes {8'h00, D} at the current address before the pixel words, with pix_ready=0 in that cycle.
REQ-032 OSRAM_SIZE_HEADER_EN undefined: no HEADER state; pixel words are packed contiguously.

Structure
REQ-033 Shared package holds the FSM state enum, ADDR_W/DATA_W defaults and the header format constant.
REQ-034 One sub-module, byte_pair_packer (hi/lo byte assembly plus odd flush), is instantiated once.

Verification
REQ-035 Macro off, BASE_ADDR=0, D=2, pixels 11,22,33,44 -> writes 0x1122@0x000, 0x3344@0x001; mat_done the cycle after.
REQ-036 Macro off, D=3, pixels 01..09 -> 5 writes: 0x0102,0x0304,0x0506,0x0708,0x0900; pix_ready low after the 9th pixel.
REQ-037 Macro on, D=2 (pixels 0xAA,0xBB,0xCC,0xDD), then a second matrix with D=1 (pixel 0x7F) -> 0x0002@0, 0xAABB@1, 0xCCDD@2, 0x0001@3, 0x7F00@4.
REQ-038 Address 0xFFF reached mid-matrix -> next word written at 0x000.
REQ-039 Reset asserted after 3 of 4 pixels, then D=2 rerun -> first write at BASE_ADDR; no write of the stale partial word.
REQ-040 mat_start pulsed mid-matrix and pix_valid gapped randomly -> output identical to the gap-free run; second mat_start ignored.
